// File: rtl/br_pkg.sv
// Shared definitions for branch resolution: condition codes, flag bit positions
// and the resolver FSM state encoding.
package br_pkg;

    localparam logic [2:0] CCC_NE  = 3'b000;
    localparam logic [2:0] CCC_EQ  = 3'b001;
    localparam logic [2:0] CCC_GT  = 3'b010;
    localparam logic [2:0] CCC_LT  = 3'b011;
    localparam logic [2:0] CCC_GE  = 3'b100;
    localparam logic [2:0] CCC_LE  = 3'b101;
    localparam logic [2:0] CCC_OV  = 3'b110;
    localparam logic [2:0] CCC_UNC = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FLAGS = 2'd1,
        ST_REDIRECT   = 2'd2
    } br_state_e;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational condition evaluator: condition code against {Z,V,N} -> taken.
// Kept free of state so the single-cycle CPU can reuse it directly.
module br_cond_eval
    import br_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z;
    logic v;
    logic n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (ccc)
            CCC_NE:  taken = ~z;
            CCC_EQ:  taken = z;
            CCC_GT:  taken = ~z & ~n;
            CCC_LT:  taken = n;
            CCC_GE:  taken = z | ~n;
            CCC_LE:  taken = z | n;
            CCC_OV:  taken = v;
            CCC_UNC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// ID-stage branch resolver: waits out in-flight flag writes, evaluates the
// condition, and issues a registered one-cycle redirect/flush for taken branches.
module branch_resolve
    import br_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int IMM_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    input  logic             br_is_reg,
    input  logic [2:0]       br_ccc,
    input  logic [IMM_W-1:0] br_imm,
    input  logic [PC_W-1:0]  pc_plus2,
    input  logic [PC_W-1:0]  rs_val,
    input  logic [2:0]       flags_q,
    input  logic [2:0]       ex_flag_wen,
    input  logic             ex_hold,
    output logic             stall_id,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush_if,
    output logic [PC_W-1:0]  br_cnt,
    output logic [PC_W-1:0]  taken_cnt
);

    br_state_e          state_q, state_d;
    logic               redirect_q, redirect_d;
    logic [PC_W-1:0]    redirect_pc_q, redirect_pc_d;
    logic [PC_W-1:0]    br_cnt_q, br_cnt_d;
    logic [PC_W-1:0]    taken_cnt_q, taken_cnt_d;

    logic               cond_taken;
    logic               eval;
    logic signed [PC_W-1:0] off_ext;
    logic [PC_W-1:0]    target;

    function automatic logic [PC_W-1:0] sat_inc(input logic [PC_W-1:0] v);
        return (&v) ? v : v + {{(PC_W-1){1'b0}}, 1'b1};
    endfunction

    br_cond_eval u_cond (
        .ccc   (br_ccc),
        .flags (flags_q),
        .taken (cond_taken)
    );

    // Word offset: sign-extend, then scale to bytes; the add wraps modulo 2^PC_W.
    assign off_ext = {{(PC_W-IMM_W){br_imm[IMM_W-1]}}, br_imm};
    assign target  = br_is_reg ? rs_val : pc_plus2 + (off_ext <<< 1);

    always_comb begin
        state_d       = state_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        br_cnt_d      = br_cnt_q;
        taken_cnt_d   = taken_cnt_q;
        stall_id      = 1'b0;
        eval          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (br_valid) begin
                    if (ex_flag_wen != 3'b000) begin
                        stall_id = 1'b1;
                        if (!ex_hold) state_d = ST_WAIT_FLAGS;
                    end else if (!ex_hold) begin
                        eval = 1'b1;
                    end
                end
            end
            ST_WAIT_FLAGS: begin
                if (ex_hold) stall_id = 1'b1;
                else         eval     = 1'b1;
            end
            // The branch sitting in ID now is on the wrong path; ignore it.
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        if (eval) begin
            br_cnt_d = sat_inc(br_cnt_q);
            if (cond_taken) begin
                taken_cnt_d   = sat_inc(taken_cnt_q);
                redirect_pc_d = target;
                redirect_d    = 1'b1;
                state_d       = ST_REDIRECT;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            taken_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            br_cnt_q      <= br_cnt_d;
            taken_cnt_q   <= taken_cnt_d;
        end
    end

    assign redirect    = redirect_q;
    assign flush_if    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign br_cnt      = br_cnt_q;
    assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: expected redirect targets are queued at
// issue and popped when the DUT pulses redirect; counters tracked by a model.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_valid = 1'b0;
    logic        br_is_reg = 1'b0;
    logic [2:0]  br_ccc = 3'b000;
    logic [8:0]  br_imm = 9'h000;
    logic [15:0] pc_plus2 = 16'h0000;
    logic [15:0] rs_val = 16'h0000;
    logic [2:0]  flags_q = 3'b000;
    logic [2:0]  ex_flag_wen = 3'b000;
    logic        ex_hold = 1'b0;
    logic        stall_id, redirect, flush_if;
    logic [15:0] redirect_pc, br_cnt, taken_cnt;

    // Narrow instance used only to reach counter saturation quickly.
    logic        s_br_valid = 1'b0;
    logic        s_stall_id, s_redirect, s_flush_if;
    logic [7:0]  s_redirect_pc, s_br_cnt, s_taken_cnt;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_br = 16'h0000;
    logic [15:0] exp_tk = 16'h0000;

    always #5 clk = ~clk;

    branch_resolve #(.PC_W(16), .IMM_W(9)) dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_is_reg(br_is_reg),
        .br_ccc(br_ccc), .br_imm(br_imm), .pc_plus2(pc_plus2), .rs_val(rs_val),
        .flags_q(flags_q), .ex_flag_wen(ex_flag_wen), .ex_hold(ex_hold),
        .stall_id(stall_id), .redirect(redirect), .redirect_pc(redirect_pc),
        .flush_if(flush_if), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
    );

    branch_resolve #(.PC_W(8), .IMM_W(4)) dut_sat (
        .clk(clk), .rst(rst), .br_valid(s_br_valid), .br_is_reg(1'b1),
        .br_ccc(3'b111), .br_imm(4'h0), .pc_plus2(8'h00), .rs_val(8'h5A),
        .flags_q(3'b000), .ex_flag_wen(3'b000), .ex_hold(1'b0),
        .stall_id(s_stall_id), .redirect(s_redirect), .redirect_pc(s_redirect_pc),
        .flush_if(s_flush_if), .br_cnt(s_br_cnt), .taken_cnt(s_taken_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_taken(input logic [2:0] ccc, input logic [2:0] f);
        logic z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (ccc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return z || n;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] model_target(input logic is_reg, input logic [8:0] imm,
                                                 input logic [15:0] pc, input logic [15:0] rs);
        logic [15:0] off;
        off = {{6{imm[8]}}, imm, 1'b0};
        return is_reg ? rs : pc + off;
    endfunction

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        if (!rst) begin
            check("flush_eq_redirect", 32'(flush_if), 32'(redirect));
            if (redirect) begin
                if (exp_q.size() == 0) check("unexpected_redirect", 32'(redirect), 32'd0);
                else check("redirect_pc", 32'(redirect_pc), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_branch(input logic is_reg, input logic [2:0] ccc, input logic [8:0] imm,
                             input logic [15:0] pc, input logic [15:0] rs, input logic [2:0] f);
        logic tk;
        tk = model_taken(ccc, f);
        @(posedge clk); #1;
        br_valid = 1'b1; br_is_reg = is_reg; br_ccc = ccc; br_imm = imm;
        pc_plus2 = pc; rs_val = rs; flags_q = f; ex_flag_wen = 3'b000;
        if (tk) begin
            exp_q.push_back(model_target(is_reg, imm, pc, rs));
            exp_tk = sat16(exp_tk);
        end
        exp_br = sat16(exp_br);
        @(negedge clk);
        check("stall_nohaz", 32'(stall_id), 32'd0);
        check("redirect_early", 32'(redirect), 32'd0);
        @(posedge clk); #1;
        br_valid = 1'b0;
        @(negedge clk);
        check("redirect_lat1", 32'(redirect), 32'(tk));
        check("br_cnt", 32'(br_cnt), 32'(exp_br));
        check("taken_cnt", 32'(taken_cnt), 32'(exp_tk));
    endtask

    task automatic do_hazard(input logic [2:0] ccc, input logic [8:0] imm, input logic [15:0] pc,
                             input logic [2:0] old_f, input logic [2:0] new_f);
        logic tk;
        tk = model_taken(ccc, new_f);
        @(posedge clk); #1;
        br_valid = 1'b1; br_is_reg = 1'b0; br_ccc = ccc; br_imm = imm; pc_plus2 = pc;
        flags_q = old_f; ex_flag_wen = 3'b111;
        @(negedge clk);
        check("haz_stall_on", 32'(stall_id), 32'd1);
        check("haz_redirect0", 32'(redirect), 32'd0);
        check("haz_br_cnt_hold", 32'(br_cnt), 32'(exp_br));
        @(posedge clk); #1;
        ex_flag_wen = 3'b000; flags_q = new_f;
        @(negedge clk);
        check("haz_stall_off", 32'(stall_id), 32'd0);
        check("haz_redirect1", 32'(redirect), 32'd0);
        if (tk) begin
            exp_q.push_back(model_target(1'b0, imm, pc, 16'h0000));
            exp_tk = sat16(exp_tk);
        end
        exp_br = sat16(exp_br);
        @(posedge clk); #1;
        br_valid = 1'b0;
        @(negedge clk);
        check("haz_redirect2", 32'(redirect), 32'(tk));
        check("haz_br_cnt", 32'(br_cnt), 32'(exp_br));
        check("haz_taken_cnt", 32'(taken_cnt), 32'(exp_tk));
    endtask

    task automatic sat_branch();
        @(posedge clk); #1;
        s_br_valid = 1'b1;
        @(posedge clk); #1;
        s_br_valid = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_redirect", 32'(redirect), 32'd0);
        check("rst_flush", 32'(flush_if), 32'd0);
        check("rst_stall", 32'(stall_id), 32'd0);
        check("rst_redirect_pc", 32'(redirect_pc), 32'd0);
        check("rst_br_cnt", 32'(br_cnt), 32'd0);
        check("rst_taken_cnt", 32'(taken_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic taken B and negative-offset wrap.
        do_branch(1'b0, 3'b001, 9'h003, 16'h0010, 16'h0000, 3'b100);
        check("t1_redirect_pc", 32'(redirect_pc), 32'h0016);
        do_branch(1'b0, 3'b011, 9'h1FF, 16'h0000, 16'h0000, 3'b001);
        check("t2_redirect_pc", 32'(redirect_pc), 32'hFFFE);
        do_branch(1'b0, 3'b011, 9'h1FF, 16'h0000, 16'h0000, 3'b000);
        check("t2_pc_holds", 32'(redirect_pc), 32'hFFFE);

        // Full condition sweep, alternating B and BR forms.
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                do_branch(1'(f % 2), 3'(c), 9'($urandom), 16'($urandom), 16'($urandom), 3'(f));
            end
        end

        // Flag hazard: evaluation must see the updated flags.
        do_hazard(3'b001, 9'h010, 16'h4000, 3'b000, 3'b100);
        do_hazard(3'b001, 9'h010, 16'h4000, 3'b100, 3'b000);
        do_hazard(3'b110, 9'h100, 16'h0100, 3'b000, 3'b010);

        // Global hold delays evaluation; hold during REDIRECT doesn't stretch it.
        @(posedge clk); #1;
        br_valid = 1'b1; br_is_reg = 1'b1; br_ccc = 3'b111; rs_val = 16'h1234;
        ex_flag_wen = 3'b000; ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_no_redirect", 32'(redirect), 32'd0);
            check("hold_br_cnt", 32'(br_cnt), 32'(exp_br));
            @(posedge clk); #1;
        end
        ex_hold = 1'b0;
        exp_q.push_back(16'h1234);
        exp_br = sat16(exp_br); exp_tk = sat16(exp_tk);
        @(negedge clk);
        check("hold_rel_redirect0", 32'(redirect), 32'd0);
        @(posedge clk); #1;
        br_valid = 1'b0; ex_hold = 1'b1;
        @(negedge clk);
        check("hold_redirect_pulse", 32'(redirect), 32'd1);
        check("hold_br_cnt_after", 32'(br_cnt), 32'(exp_br));
        @(posedge clk); #1;
        ex_hold = 1'b0;
        @(negedge clk);
        check("hold_single_pulse", 32'(redirect), 32'd0);
        check("hold_pc_holds", 32'(redirect_pc), 32'h1234);

        // Back-to-back: branch in ID during REDIRECT is ignored, next one accepted.
        @(posedge clk); #1;
        br_valid = 1'b1; br_is_reg = 1'b0; br_ccc = 3'b111; br_imm = 9'h004; pc_plus2 = 16'h0100;
        exp_q.push_back(16'h0108);
        exp_br = sat16(exp_br); exp_tk = sat16(exp_tk);
        @(posedge clk); #1;
        br_imm = 9'h001; pc_plus2 = 16'h0200;
        @(negedge clk);
        check("b2b_redirect_a", 32'(redirect), 32'd1);
        check("b2b_br_cnt_a", 32'(br_cnt), 32'(exp_br));
        @(posedge clk); #1;
        exp_q.push_back(16'h0202);
        exp_br = sat16(exp_br); exp_tk = sat16(exp_tk);
        @(negedge clk);
        check("b2b_gap", 32'(redirect), 32'd0);
        @(posedge clk); #1;
        br_valid = 1'b0;
        @(negedge clk);
        check("b2b_redirect_b", 32'(redirect), 32'd1);
        check("b2b_br_cnt_b", 32'(br_cnt), 32'(exp_br));
        check("b2b_taken_cnt_b", 32'(taken_cnt), 32'(exp_tk));

        // Saturation on the 8-bit instance: 253 taken, then 3 more must stick.
        for (int i = 0; i < 253; i++) sat_branch();
        @(negedge clk);
        check("sat_br_pre", 32'(s_br_cnt), 32'hFD);
        check("sat_tk_pre", 32'(s_taken_cnt), 32'hFD);
        check("sat_pc", 32'(s_redirect_pc), 32'h5A);
        for (int i = 0; i < 3; i++) sat_branch();
        @(negedge clk);
        check("sat_br_cnt", 32'(s_br_cnt), 32'hFF);
        check("sat_taken_cnt", 32'(s_taken_cnt), 32'hFF);
        sat_branch();
        @(negedge clk);
        check("sat_br_cnt_hold", 32'(s_br_cnt), 32'hFF);
        check("sat_taken_cnt_hold", 32'(s_taken_cnt), 32'hFF);

        // Reset while in REDIRECT.
        @(posedge clk); #1;
        br_valid = 1'b1; br_is_reg = 1'b1; br_ccc = 3'b111; rs_val = 16'hABCD;
        @(posedge clk); #1;
        br_valid = 1'b0;
        check("pre_rst_redirect", 32'(redirect), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_redirect", 32'(redirect), 32'd0);
        check("mid_rst_flush", 32'(flush_if), 32'd0);
        check("mid_rst_stall", 32'(stall_id), 32'd0);
        check("mid_rst_pc", 32'(redirect_pc), 32'd0);
        check("mid_rst_br_cnt", 32'(br_cnt), 32'd0);
        check("mid_rst_taken_cnt", 32'(taken_cnt), 32'd0);
        exp_br = 16'h0000; exp_tk = 16'h0000;
        @(posedge clk); #1;
        rst = 1'b0;
        do_branch(1'b0, 3'b000, 9'h002, 16'h0020, 16'h0000, 3'b000);
        check("post_rst_pc", 32'(redirect_pc), 32'h0024);

        repeat (2) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
